// File: rtl/des_sbox_seq.sv
// DES S1..S8 substitution, one 6-bit group per clock; DES_SBOX_PPERM_EN adds the P permutation on DONE entry.
// Latency 8 edges accept-to-out_valid; DONE holds data_out indefinitely until out_ready.
module des_sbox_seq #(
   parameter int NUM_BOX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [48:1] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:1] data_out,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   // Each table is 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
   localparam logic [255:0] S1_TAB = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
   localparam logic [255:0] S2_TAB = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
   localparam logic [255:0] S3_TAB = 256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
   localparam logic [255:0] S4_TAB = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
   localparam logic [255:0] S5_TAB = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
   localparam logic [255:0] S6_TAB = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
   localparam logic [255:0] S7_TAB = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
   localparam logic [255:0] S8_TAB = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

   if (NUM_BOX != 8) begin : g_num_box_check
      $error("des_sbox_seq: NUM_BOX must be 8");
   end

   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
      logic [255:0] tab;
      logic [5:0]   idx;
      case (box)
         3'd0:    tab = S1_TAB;
         3'd1:    tab = S2_TAB;
         3'd2:    tab = S3_TAB;
         3'd3:    tab = S4_TAB;
         3'd4:    tab = S5_TAB;
         3'd5:    tab = S6_TAB;
         3'd6:    tab = S7_TAB;
         default: tab = S8_TAB;
      endcase
      idx = {grp[5], grp[0], grp[4:1]};
      // Top bit of entry idx sits at 255-4*idx, which is {~idx, 2'b11}.
      return tab[{~idx, 2'b11} -: 4];
   endfunction

`ifdef DES_SBOX_PPERM_EN
   localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                  1, 15, 23, 26,  5, 18, 31, 10,
                                  2,  8, 24, 14, 32, 27,  3,  9,
                                 19, 13, 30,  6, 22, 11,  4, 25};

   function automatic logic [32:1] p_perm(input logic [32:1] x);
      logic [32:1] y;
      y = '0;
      // DES bit n lives at vector index 33-n.
      for (int i = 1; i <= 32; i++) begin
         y[33-i] = x[33-P_TAB[i-1]];
      end
      return y;
   endfunction
`endif

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [48:1] din_q, din_d;
   logic [32:1] dout_q, dout_d;
   logic [5:0]  grp;
   logic [3:0]  nib;
   logic [32:1] part;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      dout_d  = dout_q;
      grp     = '0;
      part    = dout_q;
      for (int k = 0; k < 8; k++) begin
         if (cnt_q == 3'(k)) grp = din_q[48-6*k -: 6];
      end
      nib = sbox_lookup(cnt_q, grp);
      for (int k = 0; k < 8; k++) begin
         if (cnt_q == 3'(k)) part[32-4*k -: 4] = nib;
      end
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               din_d   = data_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d  = cnt_q + 3'd1;
            dout_d = part;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
`ifdef DES_SBOX_PPERM_EN
               dout_d  = p_perm(part);
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         din_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign data_out  = dout_q;
endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed-plus-random bench for des_sbox_seq against a table-driven DES S-box model.
module tb_des_sbox_seq;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [48:1] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [32:1] data_out;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   des_sbox_seq #(.NUM_BOX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int sb [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
   };
   int ptab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

   // Final output as seen in DONE: raw S-box concatenation, optionally P-permuted.
   function automatic logic [31:0] finish_ref(input logic [31:0] raw);
      logic [31:0] r;
`ifdef DES_SBOX_PPERM_EN
      r = 0;
      for (int i = 0; i < 32; i++) r = (r << 1) | ((raw >> (32 - ptab[i])) & 32'd1);
`else
      r = raw;
`endif
      return r;
   endfunction

   function automatic logic [31:0] ref_model(input logic [47:0] w);
      logic [31:0] res;
      int g, row, col;
      res = 0;
      for (int k = 0; k < 8; k++) begin
         g   = int'((w >> (42 - 6*k)) & 48'h3F);
         row = ((g >> 4) & 2) | (g & 1);
         col = (g >> 1) & 15;
         res = (res << 4) | 32'(sb[k][row*16 + col]);
      end
      return finish_ref(res);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one word from IDLE and wait (bounded) for out_valid; leaves the block in DONE.
   task automatic send_wait(input logic [47:0] w, input logic [31:0] exp, input string tag);
      int lat;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      data_in  = w;
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy_run"}, 64'({busy, in_ready}), 64'b10);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd8);
      chk({tag, "_data"}, 64'(data_out), 64'(exp));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_release"}, 64'({out_valid, in_ready, busy}), 64'b010);
   endtask

   logic [31:0] expq [$];
   logic [31:0] held;
   logic [47:0] w;
   int last_done, n_done;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      #12;
      chk("reset_outs", 64'({in_ready, out_valid, busy}), 64'b100);
      chk("reset_data", 64'(data_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      send_wait(48'h000000000000, finish_ref(32'hEFA72C4D), "zero");
`ifdef DES_SBOX_PPERM_EN
      chk("zero_pperm_const", 64'(data_out), 64'hD8D8DBBC);
`endif
      release_out("zero");
      send_wait(48'hFFFFFFFFFFFF, finish_ref(32'hD9CE3DCB), "ones");
      release_out("ones");
      send_wait(48'h6C0000000000, finish_ref(32'h5FA72C4D), "s1_r1c13");
      release_out("s1_r1c13");

      for (int i = 0; i < 6; i++) begin
         w = {16'($urandom), 32'($urandom)};
         send_wait(w, ref_model(w), "rand");
         release_out("rand");
      end

      // Backpressure: DONE must hold while out_ready stays low.
      w = {16'($urandom), 32'($urandom)};
      send_wait(w, ref_model(w), "bp");
      held = data_out;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_hold_flags", 64'({out_valid, in_ready, busy}), 64'b101);
         chk("bp_hold_data", 64'(data_out), 64'(held));
      end
      release_out("bp");

      // Back-to-back with in_valid held high and data_in changing every cycle.
      in_valid = 1'b1; out_ready = 1'b1;
      data_in = {16'($urandom), 32'($urandom)};
      last_done = -1; n_done = 0;
      for (int c = 0; c < 45; c++) begin
         if (in_ready) expq.push_back(ref_model(data_in));
         tick();
         data_in = {16'($urandom), 32'($urandom)};
         if (out_valid) begin
            if (expq.size() == 0) chk("b2b_spurious", 64'd1, 64'd0);
            else chk("b2b_data", 64'(data_out), 64'(expq.pop_front()));
            if (last_done >= 0) chk("b2b_interval", 64'(c - last_done), 64'd10);
            last_done = c;
            n_done++;
         end
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20 && expq.size() != 0; c++) begin
         tick();
         if (out_valid) begin
            chk("b2b_drain_data", 64'(data_out), 64'(expq.pop_front()));
            n_done++;
         end
      end
      chk("b2b_count", 64'(n_done >= 5 && expq.size() == 0), 64'd1);
      tick();
      out_ready = 1'b0;
      chk("b2b_idle", 64'(in_ready), 64'd1);

      // Asynchronous reset in the middle of RUN.
      in_valid = 1'b1;
      data_in  = 48'hFFFFFFFFFFFF;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("mid_run_busy", 64'(busy), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_outs", 64'({in_ready, out_valid, busy}), 64'b100);
      chk("arst_data", 64'(data_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_wait(48'h000000000000, finish_ref(32'hEFA72C4D), "post_rst");
      release_out("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
